array_fill_engine: RTL

ARRAY_FILL_ENGINE -- requirements
Module: array_fill_engine

---
 rtl/array_fill_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/array_fill_engine.sv
// Memory fill engine: writes a generated pattern over DEPTH words,
// with optional read-back compare and early abort.
module array_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] step,
  input  logic              verify,
  input  logic              abort,
  output logic              finish,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              aborted,
  output logic              wr_start,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  input  logic              wr_done,
  output logic              rd_start,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_WAIT,
    S_READ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] LAST_D = DATA_W'(DEPTH - 1);

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] step_q;
  logic              verify_q;
  logic              abort_q;
  logic              finish_q;
  logic              busy_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic              aborted_q;
  logic              wr_start_q;
  logic              rd_start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data_d;
  logic              abort_now;
  logic              wr_adv;
  logic              rd_adv;
  logic              adv;
  logic              stop;
  logic              mism;

  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
    data0  = '0;
    case (mode)
      2'b00: data0 = '0;
      2'b01: data0 = fill_value;
      2'b10: data0 = fill_value;
      2'b11: data0 = LAST_D;
      default: data0 = '0;
    endcase
    data_d = '0;
    case (mode_q)
      2'b00: data_d = DATA_W'(addr_d);
      2'b01: data_d = fill_q;
      2'b10: data_d = wr_data_q + step_q;
      2'b11: data_d = LAST_D - DATA_W'(addr_d);
      default: data_d = '0;
    endcase
  end

  // A pending abort skips the read-back so no new request is issued.
  assign abort_now = abort_q | abort;
  assign mism      = rd_data_in != wr_data_q;
  assign wr_adv    = (state_q == S_WR_WAIT) && wr_done &&
                     !(verify_q && !abort_now);
  assign rd_adv    = (state_q == S_RD_WAIT) && rd_done;
  assign adv       = wr_adv | rd_adv;
  assign stop      = (addr_q == LAST_I) | abort_now;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      fill_q     <= '0;
      step_q     <= '0;
      verify_q   <= 1'b0;
      abort_q    <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      aborted_q  <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      finish_q   <= 1'b0;
      if (state_q != S_IDLE && abort) abort_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            fill_q     <= fill_value;
            step_q     <= step;
            verify_q   <= verify;
            abort_q    <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            aborted_q  <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= data0;
            busy_q     <= 1'b1;
            wr_start_q <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (wr_done && verify_q && !abort_now) begin
            rd_start_q <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (rd_done && mism && !error_q) begin
            error_q    <= 1'b1;
            err_addr_q <= addr_q;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (adv) begin
        if (stop) begin
          finish_q  <= 1'b1;
          aborted_q <= abort_now;
          state_q   <= S_DONE;
        end else begin
          addr_q     <= addr_d;
          wr_data_q  <= data_d;
          wr_start_q <= 1'b1;
          state_q    <= S_WRITE;
        end
      end
    end
  end

  assign finish      = finish_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign err_addr    = err_addr_q;
  assign aborted     = aborted_q;
  assign wr_start    = wr_start_q;
  assign rd_start    = rd_start_q;
  assign addr_out    = addr_q;
  assign wr_data_out = wr_data_q;

endmodule
